// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between an instruction-fetch requester and a
// load/store requester. Data accesses always win over fetches. Each access
// runs IDLE -> FETCH|DATA -> RESP -> IDLE. A per-access wait counter aborts
// an access that is never acknowledged and raises a sticky bus_error.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   if_req/if_addr        : fetch request and PC
//   if_rdata/if_ready     : fetched word (held) and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb       : load/store request
//   d_rdata/d_ready       : load data (held) and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb   : memory-side request, stable while mem_req=1
//   mem_rdata/mem_ack     : memory-side response, ack is a one-cycle strobe
//   stall                 : pipeline freeze while any request is outstanding
//   bus_error             : sticky, set when an access times out
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        bus_error
);

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_M1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  wait_cnt_reg;
    logic        is_data_reg;    // which requester owns the current access
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] d_rdata_reg;
    logic        bus_error_reg;

    logic        busy;
    logic        timeout_hit;

    assign busy        = (state_reg == FETCH) || (state_reg == DATA);
    // An ack in the last allowed cycle still completes normally.
    assign timeout_hit = busy && !mem_ack && (wait_cnt_reg == TIMEOUT_M1);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (d_req)
                    state_next = DATA;
                else if (if_req)
                    state_next = FETCH;
            end
            FETCH, DATA: begin
                if (mem_ack || timeout_hit)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, request latches, response data and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 8'd0;
            is_data_reg   <= 1'b0;
            addr_reg      <= 32'd0;
            we_reg        <= 1'b0;
            wdata_reg     <= 32'd0;
            wstrb_reg     <= 4'd0;
            if_rdata_reg  <= NOP_INSN;
            d_rdata_reg   <= 32'd0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    wait_cnt_reg <= 8'd0;
                    if (d_req) begin
                        is_data_reg <= 1'b1;
                        addr_reg    <= d_addr;
                        we_reg      <= d_we;
                        wdata_reg   <= d_wdata;
                        wstrb_reg   <= d_wstrb;
                    end else if (if_req) begin
                        // Fetches never write: force we/strobes low.
                        is_data_reg <= 1'b0;
                        addr_reg    <= if_addr;
                        we_reg      <= 1'b0;
                        wdata_reg   <= 32'd0;
                        wstrb_reg   <= 4'd0;
                    end
                end
                FETCH, DATA: begin
                    if (mem_ack) begin
                        if (state_reg == DATA)
                            d_rdata_reg <= mem_rdata;
                        else
                            if_rdata_reg <= mem_rdata;
                    end else if (timeout_hit) begin
                        bus_error_reg <= 1'b1;
                        // Aborted fetch returns a NOP so the pipeline can proceed.
                        if (state_reg == DATA)
                            d_rdata_reg <= 32'd0;
                        else
                            if_rdata_reg <= NOP_INSN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready pulses are suppressed when the owner has withdrawn its request.
    assign if_ready  = (state_reg == RESP) && !is_data_reg && if_req;
    assign d_ready   = (state_reg == RESP) &&  is_data_reg && d_req;

    assign mem_req   = busy;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wstrb = wstrb_reg;

    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign bus_error = bus_error_reg;

    assign stall = (if_req && !if_ready) || (d_req && !d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4). Expected completions are
// queued when a request is issued and popped when a ready pulse appears.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .bus_error (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_data, input logic [31:0] data);
        exp_t e;
        e.is_data = is_data;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_req"},   {31'd0, mem_req},   32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, "_mem_addr"},  mem_addr,           32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
        chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
        chk({tag, "_if_ready"},  {31'd0, if_ready},  32'd0);
        chk({tag, "_d_ready"},   {31'd0, d_ready},   32'd0);
        chk({tag, "_if_rdata"},  if_rdata,           32'h0000_0013);
        chk({tag, "_d_rdata"},   d_rdata,            32'd0);
        chk({tag, "_bus_error"}, {31'd0, bus_error}, 32'd0);
    endtask

    // Scoreboard: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (if_ready || d_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_ready observed if_ready=%b d_ready=%b expected no pulse",
                       if_ready, d_ready);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %s data=%h", e.is_data ? "data " : "fetch", e.is_data ? d_rdata : if_rdata);
                chk("sb_port_d_ready", {31'd0, d_ready},  {31'd0, e.is_data});
                chk("sb_port_if_ready", {31'd0, if_ready}, {31'd0, !e.is_data});
                chk("sb_data", e.is_data ? d_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed no finish expected finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        d_wstrb   = 4'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst");
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // ---------------- single fetch, ack in first FETCH cycle
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        push(1'b0, 32'h0050_0093);
        @(negedge clk);
        chk("f1_idle_mem_req", {31'd0, mem_req}, 32'd0);
        chk("f1_idle_stall",   {31'd0, stall},   32'd1);
        tick();                                  // FETCH
        mem_ack   = 1'b1;
        mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("f1_mem_req",   {31'd0, mem_req},   32'd1);
        chk("f1_mem_addr",  mem_addr,           32'h0000_0100);
        chk("f1_mem_we",    {31'd0, mem_we},    32'd0);
        chk("f1_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("f1_stall",     {31'd0, stall},     32'd1);
        tick();                                  // RESP
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        chk("f1_if_ready", {31'd0, if_ready}, 32'd1);
        chk("f1_resp_stall", {31'd0, stall}, 32'd0);
        chk("f1_resp_mem_req", {31'd0, mem_req}, 32'd0);
        tick();                                  // IDLE
        if_req = 1'b0;
        @(negedge clk);
        chk("f1_hold_if_rdata", if_rdata, 32'h0050_0093);
        chk("f1_after_if_ready", {31'd0, if_ready}, 32'd0);

        // ---------------- fetch and store arrive together
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0104;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF;
        push(1'b1, 32'hCAFE_0001);
        push(1'b0, 32'h00A0_0113);
        tick();                                  // DATA
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("c_mem_req",   {31'd0, mem_req},   32'd1);
        chk("c_mem_we",    {31'd0, mem_we},    32'd1);
        chk("c_mem_addr",  mem_addr,           32'h0000_2000);
        chk("c_mem_wdata", mem_wdata,          32'hDEAD_BEEF);
        chk("c_mem_wstrb", {28'd0, mem_wstrb}, 32'h0000_000F);
        tick();                                  // RESP (data)
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        chk("c_d_ready",  {31'd0, d_ready},  32'd1);
        chk("c_if_ready", {31'd0, if_ready}, 32'd0);
        chk("c_stall",    {31'd0, stall},    32'd1);
        tick();                                  // IDLE gap
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        chk("c_gap_mem_req", {31'd0, mem_req}, 32'd0);
        tick();                                  // FETCH
        mem_ack   = 1'b1;
        mem_rdata = 32'h00A0_0113;
        @(negedge clk);
        chk("c_f_mem_req",   {31'd0, mem_req},   32'd1);
        chk("c_f_mem_addr",  mem_addr,           32'h0000_0104);
        chk("c_f_mem_we",    {31'd0, mem_we},    32'd0);
        chk("c_f_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        tick();                                  // RESP (fetch)
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        chk("c_f_if_ready", {31'd0, if_ready}, 32'd1);
        chk("c_d_rdata_hold", d_rdata, 32'hCAFE_0001);
        tick();
        if_req = 1'b0;

        // ---------------- flush: fetch withdrawn while waiting
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        tick();                                  // FETCH cycle 0
        if_req = 1'b0;
        @(negedge clk);
        chk("fl_mem_req0", {31'd0, mem_req}, 32'd1);
        tick();                                  // cycle 1
        tick();                                  // cycle 2
        @(negedge clk);
        chk("fl_mem_req2", {31'd0, mem_req}, 32'd1);
        tick();                                  // cycle 3: ack
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();                                  // RESP
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        chk("fl_no_if_ready", {31'd0, if_ready}, 32'd0);
        chk("fl_resp_mem_req", {31'd0, mem_req}, 32'd0);
        tick();                                  // IDLE
        @(negedge clk);
        chk("fl_idle_mem_req", {31'd0, mem_req}, 32'd0);
        chk("fl_bus_error", {31'd0, bus_error}, 32'd0);

        // ---------------- timeout: no ack, mem_req for exactly 4 cycles
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        push(1'b0, 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("to_mem_req_c%0d", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("to_bus_error_c%0d", i), {31'd0, bus_error}, 32'd0);
        end
        tick();                                  // RESP
        @(negedge clk);
        chk("to_resp_mem_req", {31'd0, mem_req},   32'd0);
        chk("to_bus_error",    {31'd0, bus_error}, 32'd1);
        chk("to_if_ready",     {31'd0, if_ready},  32'd1);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("to_bus_error_sticky", {31'd0, bus_error}, 32'd1);

        // ---------------- reset in the middle of a data access
        tick();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_4000;
        tick();                                  // DATA
        @(negedge clk);
        chk("rd_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h0000_4000);
        reset = 1'b1;
        tick();                                  // reset taken
        reset     = 1'b0;
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        check_reset_values("rd");
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        chk("rd_after_d_rdata", d_rdata, 32'd0);
        chk("rd_after_mem_req", {31'd0, mem_req}, 32'd0);

        tick();
        tick();
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
